// File: rtl/sobel_core_pkg.sv
// Shared constants and helpers for the streaming 3x3 Sobel edge detector.
package sobel_core_pkg;

    localparam int PIX_W = 8;
    localparam int MAG_W = 12;
    localparam int ROW_W = 16;
    localparam logic [MAG_W-1:0] SAT_MAX = 12'd255;

    // Number of bits needed to address 0..depth-1 (clog2, minimum 1).
    function automatic int col_width(input int depth);
        int w;
        w = 32'd1;
        while ((32'd1 << w) < depth) begin
            w = w + 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sobel_core_line_buffer.sv
// One image row of pixel storage: asynchronous read, synchronous write.
// Reading and writing the same address in one cycle returns the old
// contents, which is what lets two buffers be chained into a row delay.
module sobel_line_buffer
    import sobel_core_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [PIX_W-1:0]  wdata,
    output logic [PIX_W-1:0]  rdata
);

    logic [PIX_W-1:0] mem_r [DEPTH];

    // Row storage write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/sobel_core.sv
// Streaming 3x3 Sobel edge detector, one pixel per clock, raster order.
// Output is |Gx|+|Gy| saturated to 8 bits, registered one cycle after the
// accepting edge, and flagged valid only for fully populated windows.
module sobel_core
    import sobel_core_pkg::*;
#(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             valid_in,
    output logic [PIX_W-1:0] pixel_out,
    output logic             valid_out
);

    localparam int COL_W = col_width(WIDTH);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);

    // Raster position of the pixel currently presented on pixel_in.
    logic [COL_W-1:0] col_r, col_s;
    logic [ROW_W-1:0] row_r, row_s;

    // Window: right column comes straight from the buffers and pixel_in,
    // middle (m*) and left (l*) columns are registered; index 0 is the top.
    logic [PIX_W-1:0] r0_s, r1_s, r2_s;
    logic [PIX_W-1:0] m0_r, m1_r, m2_r, m0_s, m1_s, m2_s;
    logic [PIX_W-1:0] l0_r, l1_r, l2_r, l0_s, l1_s, l2_s;

    logic [PIX_W-1:0] lb0_rd_s, lb1_rd_s;

    logic [9:0]        sum_r_s, sum_l_s, sum_b_s, sum_t_s;
    logic signed [10:0] gx_s, gy_s;
    logic [9:0]        abs_gx_s, abs_gy_s;
    logic [MAG_W-1:0]  mag_s;
    logic [PIX_W-1:0]  sat_s;

    logic [PIX_W-1:0] pixel_out_r, pixel_out_s;
    logic             valid_out_r, valid_out_s;

    // lb1 holds row r-1; its old value shifts down into lb0 (row r-2).
    sobel_line_buffer #(
        .DEPTH  (WIDTH),
        .ADDR_W (COL_W)
    ) u_lb1 (
        .clk   (clk),
        .we    (valid_in),
        .addr  (col_r),
        .wdata (pixel_in),
        .rdata (lb1_rd_s)
    );

    sobel_line_buffer #(
        .DEPTH  (WIDTH),
        .ADDR_W (COL_W)
    ) u_lb0 (
        .clk   (clk),
        .we    (valid_in),
        .addr  (col_r),
        .wdata (lb1_rd_s),
        .rdata (lb0_rd_s)
    );

    assign r0_s = lb0_rd_s;
    assign r1_s = lb1_rd_s;
    assign r2_s = pixel_in;

    // Sobel kernel: weighted column/row sums, signed gradients, saturated magnitude.
    always_comb begin
        sum_r_s = {2'b00, r0_s} + {1'b0, r1_s, 1'b0} + {2'b00, r2_s};
        sum_l_s = {2'b00, l0_r} + {1'b0, l1_r, 1'b0} + {2'b00, l2_r};
        sum_b_s = {2'b00, l2_r} + {1'b0, m2_r, 1'b0} + {2'b00, r2_s};
        sum_t_s = {2'b00, l0_r} + {1'b0, m0_r, 1'b0} + {2'b00, r0_s};
        gx_s = $signed({1'b0, sum_r_s}) - $signed({1'b0, sum_l_s});
        gy_s = $signed({1'b0, sum_b_s}) - $signed({1'b0, sum_t_s});
        if (gx_s[10]) begin
            abs_gx_s = 10'(-gx_s);
        end else begin
            abs_gx_s = gx_s[9:0];
        end
        if (gy_s[10]) begin
            abs_gy_s = 10'(-gy_s);
        end else begin
            abs_gy_s = gy_s[9:0];
        end
        mag_s = {2'b00, abs_gx_s} + {2'b00, abs_gy_s};
        if (mag_s > SAT_MAX) begin
            sat_s = PIX_W'(SAT_MAX);
        end else begin
            sat_s = mag_s[PIX_W-1:0];
        end
    end

    // Next-state for position counters, window shift and output register.
    always_comb begin
        col_s       = col_r;
        row_s       = row_r;
        m0_s        = m0_r;
        m1_s        = m1_r;
        m2_s        = m2_r;
        l0_s        = l0_r;
        l1_s        = l1_r;
        l2_s        = l2_r;
        pixel_out_s = pixel_out_r;
        valid_out_s = 1'b0;
        if (valid_in) begin
            if (col_r == COL_LAST) begin
                col_s = {COL_W{1'b0}};
                if (row_r == {ROW_W{1'b1}}) begin
                    row_s = row_r;
                end else begin
                    row_s = row_r + 16'd1;
                end
            end else begin
                col_s = col_r + COL_W'(1);
                row_s = row_r;
            end
            m0_s = r0_s;
            m1_s = r1_s;
            m2_s = r2_s;
            l0_s = m0_r;
            l1_s = m1_r;
            l2_s = m2_r;
            // Border windows are masked; stale previous-row data never escapes.
            if ((row_r >= 16'd2) && (col_r >= COL_TWO)) begin
                valid_out_s = 1'b1;
                pixel_out_s = sat_s;
            end else begin
                valid_out_s = 1'b0;
                pixel_out_s = {PIX_W{1'b0}};
            end
        end else begin
            valid_out_s = 1'b0;
            pixel_out_s = pixel_out_r;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_r       <= {COL_W{1'b0}};
            row_r       <= {ROW_W{1'b0}};
            m0_r        <= {PIX_W{1'b0}};
            m1_r        <= {PIX_W{1'b0}};
            m2_r        <= {PIX_W{1'b0}};
            l0_r        <= {PIX_W{1'b0}};
            l1_r        <= {PIX_W{1'b0}};
            l2_r        <= {PIX_W{1'b0}};
            pixel_out_r <= {PIX_W{1'b0}};
            valid_out_r <= 1'b0;
        end else begin
            col_r       <= col_s;
            row_r       <= row_s;
            m0_r        <= m0_s;
            m1_r        <= m1_s;
            m2_r        <= m2_s;
            l0_r        <= l0_s;
            l1_r        <= l1_s;
            l2_r        <= l2_s;
            pixel_out_r <= pixel_out_s;
            valid_out_r <= valid_out_s;
        end
    end

    assign pixel_out = pixel_out_r;
    assign valid_out = valid_out_r;

endmodule

// File: tb/tb_sobel_core.sv
// Self-checking bench for sobel_core with an 8x8 image. The reference model
// keeps the whole image in an array and evaluates the Sobel kernel directly
// at the window centre for every accepted pixel.
module tb_sobel_core;

    localparam int W = 8;

    logic       clk;
    logic       rst;
    logic [7:0] pixel_in;
    logic       valid_in;
    logic [7:0] pixel_out;
    logic       valid_out;

    int n_vec;
    int n_err;
    int img [W][W];
    int exp_pix;

    sobel_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .pixel_in  (pixel_in),
        .valid_in  (valid_in),
        .pixel_out (pixel_out),
        .valid_out (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        n_vec = n_vec + 1;
        if (obs !== expv) begin
            n_err = n_err + 1;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference Sobel magnitude at image centre (r, c), saturated.
    function automatic int sobel_ref(input int r, input int c);
        int gx, gy, mag;
        gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
        gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        mag = gx + gy;
        return (mag > 255) ? 255 : mag;
    endfunction

    // kind: 0 const, 1 vertical step, 2 horizontal step, 3 diagonal, 4 random
    task automatic fill(input int kind, input int lvl);
        for (int r = 0; r < W; r++) begin
            for (int c = 0; c < W; c++) begin
                case (kind)
                    0: img[r][c] = lvl;
                    1: img[r][c] = (c >= 4) ? lvl : 0;
                    2: img[r][c] = (r >= 4) ? lvl : 0;
                    3: img[r][c] = (c >= 4 && r >= 4) ? lvl : 0;
                    default: img[r][c] = $urandom_range(0, 255);
                endcase
            end
        end
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        valid_in = 1'b0;
        pixel_in = 8'd0;
        #2;
        check("rst_pixel_out", {4'd0, pixel_out}, 12'd0);
        check("rst_valid_out", {11'd0, valid_out}, 12'd0);
        tick();
        rst     = 1'b1;
        exp_pix = 0;
    endtask

    task automatic gap_cycle();
        valid_in = 1'b0;
        pixel_in = 8'($urandom_range(0, 255));
        tick();
        check("gap_valid", {11'd0, valid_out}, 12'd0);
        check("gap_hold", {4'd0, pixel_out}, 12'(exp_pix));
    endtask

    // gap_mode: 0 continuous, 1 alternate 1/0, 2 random gaps.
    task automatic run_frame(input int gap_mode, input int n_pix);
        int k;
        int ev;
        do_reset();
        k = 0;
        for (int r = 0; r < W; r++) begin
            for (int c = 0; c < W; c++) begin
                if (k < n_pix) begin
                    if (gap_mode == 2) begin
                        while ($urandom_range(0, 2) == 0) gap_cycle();
                    end
                    valid_in = 1'b1;
                    pixel_in = 8'(img[r][c]);
                    tick();
                    if (r >= 2 && c >= 2) begin
                        ev      = 1;
                        exp_pix = sobel_ref(r - 1, c - 1);
                    end else begin
                        ev      = 0;
                        exp_pix = 0;
                    end
                    check("valid_out", {11'd0, valid_out}, 12'(ev));
                    check("pixel_out", {4'd0, pixel_out}, 12'(exp_pix));
                    if (gap_mode == 1) gap_cycle();
                end
                k = k + 1;
            end
        end
        valid_in = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        exp_pix  = 0;
        rst      = 1'b0;
        valid_in = 1'b0;
        pixel_in = 8'd0;
        tick();

        fill(0, 77);   run_frame(0, W*W);
        fill(1, 50);   run_frame(0, W*W);
        fill(2, 30);   run_frame(0, W*W);
        fill(1, 255);  run_frame(0, W*W);
        fill(3, 255);  run_frame(0, W*W);
        fill(1, 50);   run_frame(1, W*W);
        // partial frame stopping mid-row 3, then reset and a fresh constant frame
        fill(1, 50);   run_frame(0, 3*W + 5);
        fill(0, 77);   run_frame(0, W*W);
        for (int i = 0; i < 6; i++) begin
            fill(4, 0);
            run_frame(2, W*W);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sobel_core.md
Name: sobel_core

Overview:
Streaming 3x3 Sobel edge detector for 8-bit grayscale raster images, one pixel per clock. Pixels arrive row-major with a valid qualifier. Two internal line buffers hold the previous rows. Each accepted pixel yields one output sample one cycle later: the gradient magnitude |Gx|+|Gy|, saturated to 8 bits, or an invalid-border indication. It sits between the image source and the edge-map sink.

Parameters:
WIDTH, 512, image row length in pixels (>=3); sizes line buffers and column counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
pixel_in  input  8  unsigned grayscale pixel, raster order
valid_in  input  1  pixel_in is accepted on this rising edge
pixel_out  output  8  saturated Sobel magnitude
valid_out  output  1  pixel_out holds a full-window result

Behaviour:
- Reset (rst low, async): col=0, row=0, pixel_out=0, valid_out=0, window column registers=0. Line buffer contents are not reset.
- Pixel counting: col counts 0..WIDTH-1 per accepted pixel, wraps to 0 and increments row. The row counter is 16 bits and saturates at all-ones. There is no frame marker; a new frame requires reset.
- Line buffers: lb1 holds row r-1 and lb0 holds row r-2, each WIDTH x 8. On each accepted pixel at column col, read lb1[col] and lb0[col], then write lb0[col]<=lb1[col] and lb1[col]<=pixel_in (read-before-write).
- Window: the current right column is {lb0[col], lb1[col], pixel_in}, top to bottom, formed combinationally. The middle and left columns are registers, shifted on each accepted pixel.
- Kernel, with p[row][col] and row 0 at the top:
  - Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20)
  - Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02)
- Arithmetic: signed 11-bit intermediates. Magnitude = |Gx|+|Gy|, 12 bits unsigned, max 2040. pixel_out = min(mag, 255).
- Latency: one cycle. The result is registered on the same edge that accepts pixel_in. The result accepted at (row, col) corresponds to window centre (row-1, col-1).
- valid_out rules:
  - valid_out<=1 on an accepting edge when row>=2 and col>=2.
  - On an accepting edge with row<2 or col<2: valid_out<=0 and pixel_out<=0.
  - Image border pixels are therefore never reported valid. Window columns may contain data from the previous row, but results are masked by col>=2.
- valid_in low: no counter, buffer or window update. valid_out<=0 and pixel_out holds its value.
- Gaps in valid_in never corrupt results: the window reflects only accepted pixels.
- Reset mid-frame: immediate return to reset state; the next accepted pixel is treated as (0,0).

Decomposition:
- Shared package: PIX_W=8, MAG_W=12, SAT_MAX=255, and a function returning the clog2 of WIDTH for the col counter width.
- One natural sub-module: sobel_line_buffer (WIDTH x 8 RAM with synchronous write and asynchronous read, read-before-write), instantiated twice.
- The kernel arithmetic stays inline.

Test Plan:
All scenarios use WIDTH=8 and an 8x8 image unless stated.
- Constant image of all 77 -> valid_out=1 exactly for row>=2 and col>=2 (36 samples), all pixel_out=0. Every other accepted cycle gives valid_out=0, pixel_out=0.
- Vertical step, cols 0-3=0 and cols 4-7=50 -> valid results at centre cols 3 and 4 equal 200; all other valid results are 0.
- Horizontal step, rows 0-3=0 and rows 4-7=30 -> valid results at centre rows 3 and 4 equal 120; others 0.
- Vertical step 0/255 -> raw magnitude 1020 -> pixel_out=255 (saturation). A diagonal step (cols>=4 and rows>=4 = 255) must also give 255 at its corners.
- Vertical-step image fed with valid_in toggling 1,0,1,0 -> the valid_out sequence and values are identical to continuous feed, with valid_out low in gap cycles and pixel_out held.
- Pull rst low mid-row 3, release, feed the constant image -> valid_out=0 for the first 2 rows and first 2 cols again; outputs match scenario 1.
